aplusbeqk_serial: RTL and testbench
===================================

Name: aplusbeqk_serial

Overview:
- Chunk-serial detector for A + B + Cin == K (mod 2^(CW*NCHUNK)). It has no carry-propagate adder; per-bit sum/carry consistency decides the result.
- Operands arrive LSB chunk first, CW bits per accepted beat, over NCHUNK beats. A 1-bit carry bridges chunk boundaries.
- Used by the FP divider and sqrt units for wide remainder-equals-target and termination checks, where a full-width compare cannot close timing in one cycle.

Parameters:
- CW, 16, chunk width in bits (>= 2)
- NCHUNK, 4, chunks per operation (>= 1); total operand width W = CW*NCHUNK

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- InValid  input  1  chunk valid
- InReady  output  1  block can accept a chunk
- A  input  CW  operand A chunk
- B  input  CW  operand B chunk
- K  input  CW  target chunk
- Cin  input  1  carry-in; sampled only on the first chunk of an operation
- Flush  input  1  abort current operation
- ResultValid  output  1  result available
- ResultReady  input  1  consumer takes result
- Eq  output  1  1 when A+B+Cin == K mod 2^W
- Busy  output  1  operation in progress (state ACC)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (resetn=0 at a clk edge): state IDLE, chunk counter 0, carry register 0, sticky-equal register 1. Outputs: InReady=1, ResultValid=0, Eq=0, Busy=0. Reset mid-operation discards all partial state.
- Handshake:
  - A chunk is accepted on a cycle with InValid && InReady.
  - The result is consumed on a cycle with ResultValid && ResultReady.
- Per accepted chunk, bitwise over j = 0..CW-1:
  - t_j = A_j ^ B_j ^ K_j
  - g_j = (A_j & B_j) | ((A_j | B_j) & ~K_j)
  - The chunk is consistent iff t_j == c_(j-1) for all j.
  - c_(-1) is Cin on the first chunk, otherwise the carry register.
  - c_j = g_j for j >= 0.
- On acceptance: carry register <= g_(CW-1); sticky <= sticky & consistent. The carry out of the final chunk is discarded (modular compare).
- States:
  - IDLE: InReady=1. An accepted chunk processes as the first chunk (sticky starts fresh at 1, c_(-1)=Cin).
    - NCHUNK=1: -> DONE.
    - Otherwise: counter=1, -> ACC.
  - ACC: InReady=1, Busy=1. Each accepted chunk increments the counter. When the accepted chunk is chunk NCHUNK-1: -> DONE, counter <= 0.
  - DONE: InReady=0, ResultValid=1, Eq = final sticky value. Eq and ResultValid are held stable until ResultReady. ResultReady=1 -> IDLE on the next edge.
- Latency: ResultValid rises the cycle after the last chunk is accepted.
- No bypass: a chunk presented while in DONE is not accepted, including the cycle ResultReady=1. It is accepted earliest in the following IDLE cycle.
- Idle cycles between chunks (InValid=0 in ACC) hold all state.
- Eq=0 whenever ResultValid=0.
- Flush:
  - In ACC: -> IDLE, counter, carry and sticky cleared. Any chunk presented the same cycle is dropped.
  - In DONE: drops the result, -> IDLE.
  - In IDLE: no effect; a same-cycle chunk is not accepted.
  - Flush has priority over acceptance and over ResultReady.
- Width rules:
  - Counter width is $clog2(NCHUNK+1).
  - No internal signal wider than CW+1 bits.
  - Combinational path from chunk inputs to registers is independent of NCHUNK.

Test Plan (CW=4, NCHUNK=2, W=8; chunks sent low then high):
- A=0x35, B=0xCB, K=0x00, Cin=0 -> sum 0x100 mod 256 = 0. Eq=1, ResultValid the cycle after the 2nd chunk.
- A=0x12, B=0x34, K=0x46 -> Eq=1. Repeat with K=0x47 -> Eq=0. Back-to-back operations with ResultReady tied high: one result per 3 cycles.
- Cross-chunk carry: A=0x08, B=0x08, K=0x10 -> Eq=1. Same A, B with K=0x00 -> Eq=0, although the low chunk alone is consistent.
- Cin: A=0x0F, B=0xF0, K=0x00, Cin=1 -> Eq=1. Cin=0 -> Eq=0. Cin toggled on the 2nd chunk must have no effect.
- Backpressure/idle:
  - Insert 3 InValid=0 cycles between chunks -> same results.
  - Hold ResultReady=0 for 5 cycles -> ResultValid and Eq stable, InReady=0.
  - A chunk presented in DONE is accepted only after the IDLE transition.
- Flush/reset:
  - Flush after the 1st chunk of a mismatching operation, then send A=0x12, B=0x34, K=0x46 -> Eq=1 (no stale sticky or carry).
  - resetn=0 during ACC -> next cycle ResultValid=0, Eq=0, InReady=1, Busy=0.

Source files
------------

// File: rtl/aplusbeqk_serial.sv
// Chunk-serial A+B+Cin==K (mod 2^(CW*NCHUNK)) detector using per-bit sum/carry consistency.
// Latency: ResultValid rises one cycle after the last chunk is accepted.
// Backpressure: InReady drops while a result waits in DONE; Flush aborts and wins over everything but reset.
module aplusbeqk_serial #(
    parameter int CW     = 16,
    parameter int NCHUNK = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          InValid,
    output logic          InReady,
    input  logic [CW-1:0] A,
    input  logic [CW-1:0] B,
    input  logic [CW-1:0] K,
    input  logic          Cin,
    input  logic          Flush,
    output logic          ResultValid,
    input  logic          ResultReady,
    output logic          Eq,
    output logic          Busy
);

    localparam int CNTW = $clog2(NCHUNK + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_carry;
    logic            r_sticky;

    logic [CW-1:0]   w_t;
    logic [CW-1:0]   w_g;
    logic [CW-1:0]   w_cprev;
    logic            w_cin;
    logic            w_consistent;
    logic            w_accept;
    logic            w_last;

    // If A+B+cin == K, K's bits are exactly the sum bits, so A^B^K recovers
    // the incoming carry at each position and g is the carry that must follow.
    assign w_t          = A ^ B ^ K;
    assign w_g          = (A & B) | ((A | B) & ~K);
    assign w_cin        = (r_state == S_IDLE) ? Cin : r_carry;
    assign w_cprev      = {w_g[CW-2:0], w_cin};
    assign w_consistent = (w_t == w_cprev);

    assign InReady      = (r_state != S_DONE);
    assign ResultValid  = (r_state == S_DONE);
    assign Busy         = (r_state == S_ACC);
    assign Eq           = ResultValid & r_sticky;

    assign w_accept     = InValid & InReady & ~Flush;
    assign w_last       = (r_cnt == CNTW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sticky <= 1'b1;
        end else if (Flush) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sticky <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_carry  <= w_g[CW-1];
                        r_sticky <= w_consistent;
                        if (NCHUNK == 1) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_ACC;
                            r_cnt   <= CNTW'(1);
                        end
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_carry  <= w_g[CW-1];
                        r_sticky <= r_sticky & w_consistent;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + CNTW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (ResultReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_carry  <= 1'b0;
                    r_sticky <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aplusbeqk_serial.sv
// Bench for aplusbeqk_serial (CW=4, NCHUNK=2): directed cases plus random traffic checked against an arithmetic model.
module tb_aplusbeqk_serial;

    localparam int CW = 4;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [CW-1:0] A = '0;
    logic [CW-1:0] B = '0;
    logic [CW-1:0] K = '0;
    logic          Cin = 1'b0;
    logic          Flush = 1'b0;
    logic          ResultValid;
    logic          ResultReady = 1'b0;
    logic          Eq;
    logic          Busy;

    int checks = 0;
    int errors = 0;

    aplusbeqk_serial #(.CW(CW), .NCHUNK(NC)) dut (
        .clk(clk), .resetn(resetn), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .K(K), .Cin(Cin), .Flush(Flush),
        .ResultValid(ResultValid), .ResultReady(ResultReady), .Eq(Eq), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: collects whole operands, decides Eq with integer addition.
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_eq   = 1'b0;
    int m_a, m_b, m_k;
    bit m_cin;
    bit chk_en = 1'b0;
    int n_eq1  = 0;

    always @(posedge clk) begin
        if (!resetn || Flush) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (ResultReady) m_done = 1'b0;
        end else if (InValid) begin
            if (m_cnt == 0) begin
                m_a = 0; m_b = 0; m_k = 0; m_cin = Cin;
            end
            m_a = m_a | (int'(A) << (CW * m_cnt));
            m_b = m_b | (int'(B) << (CW * m_cnt));
            m_k = m_k | (int'(K) << (CW * m_cnt));
            m_cnt++;
            if (m_cnt == NC) begin
                m_eq   = ((m_a + m_b + int'(m_cin)) % (1 << (CW * NC))) == m_k;
                m_done = 1'b1;
                m_cnt  = 0;
                if (m_eq) n_eq1++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_inready", InReady, !m_done);
            chk("model_rvalid", ResultValid, m_done);
            chk("model_eq", Eq, m_done && m_eq);
            chk("model_busy", Busy, m_cnt != 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends both chunks; returns just after the edge that accepted the last one.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] k,
                           input logic cin, input logic cin2, input int gap);
        InValid = 1'b1; A = a[3:0]; B = b[3:0]; K = k[3:0]; Cin = cin;
        tick;
        InValid = 1'b0;
        repeat (gap) tick;
        InValid = 1'b1; A = a[7:4]; B = b[7:4]; K = k[7:4]; Cin = cin2;
        tick;
        InValid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] k, input logic cin, input logic cin2,
                          input int gap, input logic exp);
        send_op(a, b, k, cin, cin2, gap);
        chk({name, "_rvalid"}, ResultValid, 1'b1);
        chk({name, "_eq"}, Eq, exp);
        ResultReady = 1'b1;
        tick;
        ResultReady = 1'b0;
    endtask

    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_k [3];
    logic       bb_e [3];

    initial begin
        int lo;
        resetn = 1'b0;
        tick;
        tick;
        chk_en = 1'b1;
        chk("rst_inready", InReady, 1'b1);
        chk("rst_rvalid", ResultValid, 1'b0);
        chk("rst_eq", Eq, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        resetn = 1'b1;
        tick;

        run_op("wrap", 8'h35, 8'hCB, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        run_op("simple_eq", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0, 1'b1);
        run_op("simple_ne", 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 0, 1'b0);
        run_op("xcarry_eq", 8'h08, 8'h08, 8'h10, 1'b0, 1'b0, 0, 1'b1);
        run_op("xcarry_ne", 8'h08, 8'h08, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        run_op("cin1", 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b1, 0, 1'b1);
        run_op("cin0", 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        run_op("cin_late", 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 0, 1'b1);
        run_op("cin_late0", 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        run_op("gap_eq", 8'h08, 8'h08, 8'h10, 1'b0, 1'b0, 3, 1'b1);
        run_op("gap_ne", 8'h12, 8'h34, 8'h47, 1'b0, 1'b0, 3, 1'b0);

        // Back-to-back with ResultReady held high: chunk, chunk, result cycle.
        bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_k[0] = 8'h46; bb_e[0] = 1'b1;
        bb_a[1] = 8'h12; bb_b[1] = 8'h34; bb_k[1] = 8'h47; bb_e[1] = 1'b0;
        bb_a[2] = 8'h35; bb_b[2] = 8'hCB; bb_k[2] = 8'h00; bb_e[2] = 1'b1;
        ResultReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_op(bb_a[i], bb_b[i], bb_k[i], 1'b0, 1'b0, 0);
            chk("b2b_rvalid", ResultValid, 1'b1);
            chk("b2b_eq", Eq, bb_e[i]);
            tick;
            chk("b2b_ready", InReady, 1'b1);
        end
        ResultReady = 1'b0;

        // Result held under backpressure while a chunk waits on the input.
        send_op(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0);
        InValid = 1'b1; A = 4'h2; B = 4'h4; K = 4'h6; Cin = 1'b0;
        repeat (5) begin
            tick;
            chk("hold_rvalid", ResultValid, 1'b1);
            chk("hold_eq", Eq, 1'b1);
            chk("hold_inready", InReady, 1'b0);
        end
        ResultReady = 1'b1;
        tick;
        ResultReady = 1'b0;
        chk("nobypass_busy", Busy, 1'b0);
        chk("nobypass_rvalid", ResultValid, 1'b0);
        tick;
        chk("idle_accept_busy", Busy, 1'b1);
        A = 4'h1; B = 4'h3; K = 4'h4;
        tick;
        InValid = 1'b0;
        chk("after_done_rvalid", ResultValid, 1'b1);
        chk("after_done_eq", Eq, 1'b1);
        ResultReady = 1'b1;
        tick;
        ResultReady = 1'b0;

        // Flush in ACC with a mismatching first chunk, then a clean operation.
        InValid = 1'b1; A = 4'h1; B = 4'h1; K = 4'hF; Cin = 1'b0;
        tick;
        Flush = 1'b1;
        tick;
        Flush = 1'b0; InValid = 1'b0;
        chk("flush_acc_busy", Busy, 1'b0);
        chk("flush_acc_inready", InReady, 1'b1);
        run_op("post_flush", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0, 1'b1);

        Flush = 1'b1; InValid = 1'b1; A = 4'h2; B = 4'h4; K = 4'h6;
        tick;
        Flush = 1'b0; InValid = 1'b0;
        chk("flush_idle_busy", Busy, 1'b0);

        send_op(8'h35, 8'hCB, 8'h00, 1'b0, 1'b0, 0);
        Flush = 1'b1;
        tick;
        Flush = 1'b0;
        chk("flush_done_rvalid", ResultValid, 1'b0);
        chk("flush_done_eq", Eq, 1'b0);

        // Reset in the middle of an operation.
        InValid = 1'b1; A = 4'h5; B = 4'h3; K = 4'h8;
        tick;
        InValid = 1'b0;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        chk("rst_acc_rvalid", ResultValid, 1'b0);
        chk("rst_acc_eq", Eq, 1'b0);
        chk("rst_acc_inready", InReady, 1'b1);
        chk("rst_acc_busy", Busy, 1'b0);
        run_op("post_rst", 8'h08, 8'h08, 8'h10, 1'b0, 1'b0, 0, 1'b1);

        // Random traffic; about half the K chunks are steered to match the running sum.
        for (int c = 0; c < 4000; c++) begin
            InValid     = ($urandom % 4) != 0;
            A           = 4'($urandom);
            B           = 4'($urandom);
            Cin         = 1'($urandom);
            ResultReady = ($urandom % 3) == 0;
            Flush       = ($urandom % 40) == 0;
            resetn      = ($urandom % 300) != 0;
            if ($urandom % 2 == 1) begin
                if (m_cnt == 0) begin
                    K = 4'(int'(A) + int'(B) + int'(Cin));
                end else begin
                    lo = m_a + m_b + int'(m_cin);
                    K = 4'((lo >> CW) + int'(A) + int'(B));
                end
            end else begin
                K = 4'($urandom);
            end
            tick;
        end
        resetn = 1'b1; Flush = 1'b0; InValid = 1'b0; ResultReady = 1'b1;
        tick;
        tick;
        checks++;
        if (n_eq1 < 20) begin
            errors++;
            $display("FAIL rand_eq_coverage: got %0d equal results required at least 20", n_eq1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
